// File: rtl/div_pkg.sv
// Shared definitions for the sequential integer divider: op encodings,
// FSM state type and the iteration-counter width helper.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Counter needs to reach WIDTH-1; guard the degenerate width of 1.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/int_div_step.sv
// One combinational restoring-division iteration: trial-subtract the divisor
// from {acc, next dividend bit} and keep the difference when it is non-negative.
module int_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic             i_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_qbit
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;

  assign w_trial = {i_acc, i_msb};
  // acc < divisor always holds, so bit WIDTH of the difference is a true sign bit.
  assign w_diff  = w_trial - {1'b0, i_divisor};
  assign o_qbit  = ~w_diff[WIDTH];
  assign o_acc   = o_qbit ? w_diff[WIDTH-1:0] : {i_acc[WIDTH-2:0], i_msb};

endmodule

// File: rtl/int_div_seq.sv
// Multi-cycle restoring divider with RISC-V DIV/DIVU/REM/REMU semantics,
// valid/ready on request and response, flush and tag pass-through.
module int_div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             dbz_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high (valid_i/ready_o for requests, valid_o/ready_i for responses);
  // valid_o and the response fields stay stable until that transfer or a flush.

  localparam int             CW      = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, r_dvd, r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q, r_neg_r, r_rem_sel;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_quot, r_rem, r_res;
  logic [TAG_W-1:0] r_tag_o;
  logic             r_dbz;

  logic             w_accept, w_signed, w_neg_dvd, w_neg_dvs;
  logic             w_dbz, w_ovf, w_special, w_last;
  logic [WIDTH-1:0] w_abs_dvd, w_abs_dvs, w_fast_q, w_fast_r;
  logic [WIDTH-1:0] w_acc_nxt, w_fix_q, w_fix_r;
  logic             w_qbit;

  assign ready_o     = (r_state == IDLE);
  assign valid_o     = (r_state == DONE);
  assign result_o    = r_res;
  assign quotient_o  = r_quot;
  assign remainder_o = r_rem;
  assign tag_o       = r_tag_o;
  assign dbz_o       = r_dbz;
  assign dbg_state_o = r_state;

  assign w_accept  = valid_i && ready_o && !flush_i;
  assign w_signed  = ~op_i[0];
  assign w_neg_dvd = w_signed && dividend_i[WIDTH-1];
  assign w_neg_dvs = w_signed && divisor_i[WIDTH-1];
  // The most-negative value negates to itself, which is its correct magnitude.
  assign w_abs_dvd = w_neg_dvd ? -dividend_i : dividend_i;
  assign w_abs_dvs = w_neg_dvs ? -divisor_i  : divisor_i;

  assign w_dbz     = (divisor_i == '0);
  assign w_ovf     = w_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
  assign w_special = w_dbz || w_ovf;
  assign w_fast_q  = w_dbz ? '1 : dividend_i;
  assign w_fast_r  = w_dbz ? dividend_i : '0;

  assign w_last    = (r_cnt == LAST);
  assign w_fix_q   = r_neg_q ? -r_dvd : r_dvd;
  assign w_fix_r   = r_neg_r ? -r_acc : r_acc;

  int_div_step #(.WIDTH(WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_msb     (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_acc     (w_acc_nxt),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : CALC;
      CALC:    if (w_last)   w_state_nxt = FIXUP;
      FIXUP:                 w_state_nxt = DONE;
      DONE:    if (ready_i)  w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
    if (flush_i) w_state_nxt = IDLE;
  end

  // r_dvd doubles as the quotient register: dividend bits shift out the top
  // while quotient bits shift in at the bottom.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_acc     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
      r_tag     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_res     <= '0;
      r_tag_o   <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc     <= '0;
            r_dvd     <= w_abs_dvd;
            r_dvs     <= w_abs_dvs;
            r_cnt     <= '0;
            r_neg_q   <= w_neg_dvd ^ w_neg_dvs;
            r_neg_r   <= w_neg_dvd;
            r_rem_sel <= op_i[1];
            r_tag     <= tag_i;
            if (w_special) begin
              r_quot  <= w_fast_q;
              r_rem   <= w_fast_r;
              r_res   <= op_i[1] ? w_fast_r : w_fast_q;
              r_tag_o <= tag_i;
              r_dbz   <= w_dbz;
            end
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
        end
        FIXUP: begin
          if (!flush_i) begin
            r_quot  <= w_fix_q;
            r_rem   <= w_fix_r;
            r_res   <= r_rem_sel ? w_fix_r : w_fix_q;
            r_tag_o <= r_tag;
            r_dbz   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_seq.sv
// Directed bench for int_div_seq: driver pushes hand-computed responses into a
// queue, a negedge monitor compares every presented response against it.
module tb_int_div_seq;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [1:0]    op_i = 2'b00;
  logic [W-1:0]  dividend_i = '0;
  logic [W-1:0]  divisor_i = '0;
  logic [TW-1:0] tag_i = '0;
  logic          flush_i = 1'b0;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [W-1:0]  result_o, quotient_o, remainder_o;
  logic [TW-1:0] tag_o;
  logic          dbz_o;
  logic [1:0]    dbg_state_o;

  int_div_seq #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .tag_i       (tag_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .tag_o       (tag_o),
    .dbz_o       (dbz_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int edge_cnt = 0;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0]  res;
    logic [W-1:0]  quot;
    logic [W-1:0]  rem;
    logic [TW-1:0] tag;
    logic          dbz;
    int            lat;
    int            acc_edge;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  logic prev_valid = 1'b0;
  always @(negedge clk_i) begin
    exp_t h;
    if (rst_ni) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_response: got valid_o=1 expected no response (tag 0x%02h)", tag_o);
        end else begin
          h = exp_q[0];
          if (!prev_valid) chk("latency", W'(edge_cnt - h.acc_edge + 1), W'(h.lat));
          chk("result", result_o, h.res);
          chk("quotient", quotient_o, h.quot);
          chk("remainder", remainder_o, h.rem);
          chk("tag", W'(tag_o), W'(h.tag));
          chk("dbz", W'(dbz_o), W'(h.dbz));
          if (ready_i) void'(exp_q.pop_front());
        end
      end
    end
    prev_valid = valid_o;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic dbz, input int lat, input bit push);
    exp_t e;
    int t = 0;
    @(negedge clk_i);
    while (!ready_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (!ready_o) begin
      n_checks++;
      n_err++;
      $display("FAIL issue_timeout: got ready_o=0 expected 1 within 200 cycles");
      return;
    end
    op_i = op; dividend_i = a; divisor_i = b; tag_i = tag; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    if (push) begin
      e.res = op[1] ? r : q; e.quot = q; e.rem = r; e.tag = tag; e.dbz = dbz;
      e.lat = lat; e.acc_edge = edge_cnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk_i); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    // Reset wins even with a request offered.
    valid_i = 1'b1; divisor_i = 32'd3; dividend_i = 32'd9;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", W'(ready_o), 1);
    chk("rst_valid", W'(valid_o), 0);
    chk("rst_result", result_o, 0);
    chk("rst_quot", quotient_o, 0);
    chk("rst_rem", remainder_o, 0);
    chk("rst_tag", W'(tag_o), 0);
    chk("rst_dbz", W'(dbz_o), 0);
    chk("rst_state", W'(dbg_state_o), 0);
    valid_i = 1'b0;
    rst_ni = 1'b1;

    // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
    issue(2'b01, 32'd100, 32'd7, 5'h01, 32'd14, 32'd2, 1'b0, 34, 1'b1);
    drain();
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'h02, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b1);
    drain();
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 5'h03, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 34, 1'b1);
    drain();
    issue(2'b00, 32'd5, 32'd0, 5'h04, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b1);
    drain();
    issue(2'b11, 32'hDEAD_BEEF, 32'd0, 5'h05, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1, 1'b1);
    drain();
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'h06, 32'h8000_0000, 32'd0, 1'b0, 1, 1'b1);
    drain();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'h07, 32'h8000_0000, 32'd0, 1'b0, 1, 1'b1);
    drain();
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'h08, 32'd0, 32'h8000_0000, 1'b0, 34, 1'b1);
    drain();
    issue(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'h09, 32'd14, 32'hFFFF_FFFE, 1'b0, 34, 1'b1);
    drain();

    // Backpressure: hold the response, offer junk requests that must be ignored.
    ready_i = 1'b0;
    issue(2'b01, 32'd1000, 32'd10, 5'h13, 32'd100, 32'd0, 1'b0, 34, 1'b1);
    t = 0;
    while (!valid_o && t < 100) begin
      @(posedge clk_i); #1;
      t++;
    end
    chk("bp_valid_seen", W'(valid_o), 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", W'(ready_o), 0);
      valid_i = 1'b1; op_i = 2'($urandom_range(0, 3));
      dividend_i = $urandom; divisor_i = $urandom; tag_i = 5'h1F;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    drain();
    @(posedge clk_i); #1;
    chk("bp_idle_after", W'(ready_o), 1);

    // Flush at CALC iteration 10.
    issue(2'b01, 32'd1000, 32'd7, 5'h0A, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    repeat (9) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_ready", W'(ready_o), 1);
    chk("flush_valid", W'(valid_o), 0);
    chk("flush_keeps_quot", quotient_o, 32'd100);

    // Flush in IDLE with a request offered: not accepted.
    valid_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; dividend_i = 32'd9; divisor_i = 32'd3;
    @(posedge clk_i); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_idle_noaccept", W'(ready_o), 1);

    // Reset mid-CALC.
    issue(2'b01, 32'd1000, 32'd7, 5'h0B, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    repeat (5) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    chk("midrst_ready", W'(ready_o), 1);
    chk("midrst_valid", W'(valid_o), 0);
    chk("midrst_quot", quotient_o, 0);
    repeat (40) @(posedge clk_i);
    #1;

    issue(2'b01, 32'd9, 32'd3, 5'h0C, 32'd3, 32'd0, 1'b0, 34, 1'b1);
    drain();
    repeat (3) @(posedge clk_i);
    #1;
    chk("queue_empty", W'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
